interfaz_tx: RTL and testbench
==============================

# interfaz_tx

Transmit-side counterpart of the UART-to-ALU receive interface. It captures an ALU result on a completion pulse and serialises it into bytes for the UART transmitter. It issues one start pulse per byte and waits for the transmitter's done pulse before sending the next byte. It sits between the ALU output and the UART TX core, mirroring the receive interface that assembles A/B/OP from UART RX bytes.

## Interface
- DBIT, 8: UART data byte width.
- NB_RESULT, 8: ALU result width; must be an integer multiple of DBIT.
- NB_BYTES, NB_RESULT/DBIT: derived localparam; number of result bytes per frame.
- i_clk  input  1  system clock; all logic on the rising edge.
- i_rst  input  1  asynchronous, active-low reset.
- i_result  input  NB_RESULT  signed ALU result; sampled only when i_alu_done=1 and the block is idle.
- i_alu_done  input  1  one-cycle pulse: result valid.
- i_tx_done  input  1  one-cycle pulse from the UART TX: current byte fully sent.
- o_tx_start  output  1  one-cycle pulse: UART TX loads o_data.
- o_data  output  DBIT  byte to transmit.
- o_busy  output  1  frame in progress.
- o_frame_done  output  1  one-cycle pulse after the last byte's i_tx_done.

## Operation
- States: IDLE, START, WAIT, DONE.
- IDLE, i_alu_done=1: latch i_result into the shift register; byte index=0; go to START. i_tx_done is ignored.
- START: o_tx_start=1 for exactly this cycle. o_data = byte[index], LSB byte first. Go to WAIT.
- WAIT: hold o_data. On i_tx_done: if index==NB_BYTES-1 (or the checksum byte when enabled), go to DONE; else index++ and go to START.
- DONE: o_frame_done=1 for one cycle, then IDLE.
- o_busy=1 in START, WAIT and DONE.
- An i_alu_done arriving while o_busy=1 is dropped. The captured result is not altered.
- i_tx_done is sampled only in WAIT. A pulse in START is ignored.
- o_data always comes from registers, never combinational from i_result.

## Timing
- Reset values: state=IDLE, o_tx_start=0, o_data=0, o_busy=0, o_frame_done=0, index=0, shift register=0.
- i_alu_done at edge n: o_tx_start and o_busy are high in cycle n+1, and o_data is valid in n+1.
- o_data is stable from the start pulse until the cycle after the matching i_tx_done.
- i_tx_done at edge m, not last byte: next o_tx_start is in cycle m+1.
- i_tx_done at edge m, last byte: o_frame_done in m+1 and o_busy still 1. IDLE in m+2, where a new i_alu_done is accepted.
- Minimum frame: 2 + NB_BYTES×(1 + TX latency) + 1 cycles.
- Reset asserted mid-frame: immediate return to reset values; no further o_tx_start. A pending TX byte is abandoned and its i_tx_done is ignored.

## Configuration
- INTERFAZ_TX_CHECKSUM_EN defined: one extra byte is sent after the result bytes. Its value is the XOR of all result bytes, sent with its own START/WAIT pair. o_frame_done follows the checksum's i_tx_done.
- Undefined: exactly NB_BYTES bytes per frame; no checksum logic is synthesised.

## Structure
- Shared package/header (common with interfaz_rx): DBIT and NB_RESULT defaults, state encodings (2-bit), and the INTERFAZ_TX_CHECKSUM_EN guard.
- Single module; no sub-module. Byte selection is an index-driven mux over the latched result.
- Checksum accumulator is inline, under the macro.

## Test plan
- Reset: hold i_rst=0 with toggling inputs -> all outputs 0 and no o_tx_start; release -> still idle.
- Single byte: NB_RESULT=8, i_result=8'h06, i_alu_done pulse -> o_tx_start next cycle with o_data=8'h06. i_tx_done 10 cycles later -> o_frame_done one cycle later, then o_busy=0.
- Multi-byte: NB_RESULT=16, i_result=16'hFFFE (−2) -> bytes 8'hFE then 8'hFF, second o_tx_start exactly one cycle after the first i_tx_done.
- Overlap: second i_alu_done (8'h22) during WAIT of 8'h05 -> only 8'h05 sent. A fresh pulse after idle -> 8'h22 sent.
- Reset mid-frame: i_rst low during WAIT -> outputs cleared. A later i_tx_done pulse -> no o_tx_start and no o_frame_done.
- Checksum (macro defined, NB_RESULT=16): result 16'h1234 -> bytes 8'h34, 8'h12, 8'h26; o_frame_done after the third i_tx_done.

Source files
------------

// File: rtl/interfaz_tx_pkg.sv
// ============================================================================
// interfaz_tx_pkg
// Shared defaults and state encoding for the UART/ALU interface blocks.
// INTERFAZ_TX_CHECKSUM_EN appends an XOR checksum byte to every frame.
// Revision: 1.0
// ============================================================================
`default_nettype none

package interfaz_tx_pkg;

  localparam int DBIT_DEFAULT      = 8;
  localparam int NB_RESULT_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

`ifdef INTERFAZ_TX_CHECKSUM_EN
  localparam int CHECKSUM_BYTES = 1;
`else
  localparam int CHECKSUM_BYTES = 0;
`endif

endpackage

`default_nettype wire

// File: rtl/interfaz_tx.sv
// ============================================================================
// interfaz_tx
// Captures an ALU result and sends it LSB byte first to the UART transmitter,
// one start pulse per byte. INTERFAZ_TX_CHECKSUM_EN adds a trailing XOR byte.
// Revision: 1.0
// ============================================================================
`default_nettype none

module interfaz_tx
  import interfaz_tx_pkg::*;
#(
  parameter int DBIT      = DBIT_DEFAULT,
  parameter int NB_RESULT = NB_RESULT_DEFAULT
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic signed [NB_RESULT-1:0] i_result,
  input  logic                        i_alu_done,
  input  logic                        i_tx_done,
  output logic                        o_tx_start,
  output logic [DBIT-1:0]             o_data,
  output logic                        o_busy,
  output logic                        o_frame_done
);

  localparam int NB_BYTES = NB_RESULT / DBIT;
  localparam int NB_TX    = NB_BYTES + CHECKSUM_BYTES;
  localparam int IDX_W    = $clog2(NB_TX + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_TX - 1);

  state_e                 state_d, state_q;
  logic [IDX_W-1:0]       idx_d, idx_q;
  logic [NB_RESULT-1:0]   result_d, result_q;
  logic [DBIT-1:0]        data_d, data_q;
  logic                   tx_start_d, tx_start_q;
  logic                   busy_d, busy_q;
  logic                   frame_done_d, frame_done_q;
  logic [IDX_W-1:0]       w_next_idx;
  logic [DBIT-1:0]        w_bytes [NB_BYTES];

  for (genvar b = 0; b < NB_BYTES; b++) begin : g_bytes
    assign w_bytes[b] = result_q[b*DBIT +: DBIT];
  end

`ifdef INTERFAZ_TX_CHECKSUM_EN
  logic [DBIT-1:0] chk_d, chk_q;
  logic [DBIT-1:0] w_in_bytes [NB_BYTES];

  for (genvar b = 0; b < NB_BYTES; b++) begin : g_in_bytes
    assign w_in_bytes[b] = i_result[b*DBIT +: DBIT];
  end

  // Checksum is folded at capture time so the last byte is ready without delay.
  always_comb begin
    chk_d = chk_q;
    if (state_q == ST_IDLE && i_alu_done) begin
      chk_d = '0;
      for (int k = 0; k < NB_BYTES; k++) chk_d = chk_d ^ w_in_bytes[k];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) chk_q <= '0;
    else        chk_q <= chk_d;
  end
`endif

  function automatic logic [DBIT-1:0] pick_byte(input logic [IDX_W-1:0] idx);
    logic [DBIT-1:0] r;
    r = '0;
    for (int k = 0; k < NB_BYTES; k++) begin
      if (idx == IDX_W'(k)) r = w_bytes[k];
    end
`ifdef INTERFAZ_TX_CHECKSUM_EN
    if (idx == IDX_W'(NB_BYTES)) r = chk_q;
`endif
    return r;
  endfunction

  assign w_next_idx = idx_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    result_d     = result_q;
    data_d       = data_q;
    tx_start_d   = 1'b0;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_alu_done) begin
          state_d    = ST_START;
          idx_d      = '0;
          result_d   = i_result;
          data_d     = i_result[DBIT-1:0];
          tx_start_d = 1'b1;
          busy_d     = 1'b1;
        end
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        if (i_tx_done) begin
          if (idx_q == LAST_IDX) begin
            state_d      = ST_DONE;
            frame_done_d = 1'b1;
          end else begin
            state_d    = ST_START;
            idx_d      = w_next_idx;
            data_d     = pick_byte(w_next_idx);
            tx_start_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      result_q     <= '0;
      data_q       <= '0;
      tx_start_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      result_q     <= result_d;
      data_q       <= data_d;
      tx_start_q   <= tx_start_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign o_tx_start   = tx_start_q;
  assign o_data       = data_q;
  assign o_busy       = busy_q;
  assign o_frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_interfaz_tx.sv
// ============================================================================
// tb_interfaz_tx
// Directed bench for interfaz_tx with 8-bit and 16-bit result instances.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_interfaz_tx;

`ifdef INTERFAZ_TX_CHECKSUM_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  res8 = '0;
  logic [15:0] res16 = '0;
  logic        alu8 = 1'b0, alu16 = 1'b0, txd8 = 1'b0, txd16 = 1'b0;
  logic        start8, start16, busy8, busy16, fd8, fd16;
  logic [7:0]  data8, data16;
  bit          sel = 1'b0;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    bit          sel;
    logic [15:0] result;
    logic [23:0] eb;
    int          lat;
    int          mode;
  } vec_t;

  vec_t vecs [7];

  always #5 clk = ~clk;

  interfaz_tx #(.DBIT(8), .NB_RESULT(8)) u_dut8 (
    .i_clk(clk), .i_rst(rst_n), .i_result(res8), .i_alu_done(alu8),
    .i_tx_done(txd8), .o_tx_start(start8), .o_data(data8), .o_busy(busy8),
    .o_frame_done(fd8)
  );

  interfaz_tx #(.DBIT(8), .NB_RESULT(16)) u_dut16 (
    .i_clk(clk), .i_rst(rst_n), .i_result(res16), .i_alu_done(alu16),
    .i_tx_done(txd16), .o_tx_start(start16), .o_data(data16), .o_busy(busy16),
    .o_frame_done(fd16)
  );

  wire       s_start = sel ? start16 : start8;
  wire       s_busy  = sel ? busy16  : busy8;
  wire       s_fd    = sel ? fd16    : fd8;
  wire [7:0] s_data  = sel ? data16  : data8;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_pulses();
    alu8 = 1'b0; alu16 = 1'b0; txd8 = 1'b0; txd16 = 1'b0;
  endtask

  task automatic drive_alu(input logic [15:0] r);
    if (sel) begin res16 = r; alu16 = 1'b1; end
    else     begin res8 = r[7:0]; alu8 = 1'b1; end
  endtask

  task automatic drive_txd();
    if (sel) txd16 = 1'b1; else txd8 = 1'b1;
  endtask

  // mode 1: extra alu_done during first WAIT; mode 2: tx_done during first START
  task automatic run_frame(input logic [15:0] r, input logic [23:0] eb, input int lat, input int mode);
    int nb;
    nb = (sel ? 2 : 1) + CHK;
    @(negedge clk); drive_alu(r);
    @(negedge clk); clear_pulses();
    for (int i = 0; i < nb; i++) begin
      chk("start_pulse", {31'd0, s_start}, 32'd1);
      chk("byte_data", {24'd0, s_data}, {24'd0, eb[8*i +: 8]});
      chk("busy_in_frame", {31'd0, s_busy}, 32'd1);
      if (i == 0 && mode == 2) drive_txd();
      for (int c = 0; c < lat; c++) begin
        @(negedge clk); clear_pulses();
        chk("wait_hold", {22'd0, s_start, s_fd, s_data}, {22'd0, 2'b00, eb[8*i +: 8]});
        if (i == 0 && c == 0 && mode == 1) drive_alu(16'h2222);
      end
      drive_txd();
      @(negedge clk); clear_pulses();
    end
    chk("frame_done", {31'd0, s_fd}, 32'd1);
    chk("busy_at_done", {31'd0, s_busy}, 32'd1);
    chk("start_at_done", {31'd0, s_start}, 32'd0);
    @(negedge clk);
    chk("idle_after", {29'd0, s_busy, s_fd, s_start}, 32'd0);
    @(negedge clk);
    chk("still_idle", {29'd0, s_busy, s_fd, s_start}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 16'h0006, 24'h000606, 10, 0};
    vecs[1] = '{1'b1, 16'hFFFE, 24'h01FFFE, 3, 0};
    vecs[2] = '{1'b1, 16'h1234, 24'h261234, 2, 2};
    vecs[3] = '{1'b0, 16'h0005, 24'h000505, 4, 1};
    vecs[4] = '{1'b0, 16'h0022, 24'h002222, 1, 0};
    vecs[5] = '{1'b1, 16'h8001, 24'h818001, 1, 0};
    vecs[6] = '{1'b1, 16'hA55A, 24'hFFA55A, 5, 1};

    // Reset held with toggling inputs
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      res8 = 8'h5A; res16 = 16'hBEEF;
      alu8 = i[0]; alu16 = i[0]; txd8 = ~i[0]; txd16 = ~i[0];
      chk("rst_out8", {21'd0, start8, busy8, fd8, data8}, 32'd0);
      chk("rst_out16", {21'd0, start16, busy16, fd16, data16}, 32'd0);
    end
    @(negedge clk); clear_pulses(); rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst8", {21'd0, start8, busy8, fd8, data8}, 32'd0);
    chk("post_rst16", {21'd0, start16, busy16, fd16, data16}, 32'd0);

    for (int v = 0; v < 7; v++) begin
      sel = vecs[v].sel;
      run_frame(vecs[v].result, vecs[v].eb, vecs[v].lat, vecs[v].mode);
    end

    // Reset in the middle of a frame
    sel = 1'b1;
    @(negedge clk); drive_alu(16'hFFFE);
    @(negedge clk); clear_pulses();
    @(negedge clk);
    chk("pre_rst_wait", {23'd0, s_busy, s_data}, {23'd0, 1'b1, 8'hFE});
    rst_n = 1'b0;
    #1;
    chk("midrst_clear", {21'd0, s_start, s_busy, s_fd, s_data}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); drive_txd();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); clear_pulses();
      chk("after_rst_quiet", {21'd0, s_start, s_busy, s_fd, s_data}, 32'd0);
    end
    run_frame(16'h1234, 24'h261234, 2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
